// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the direct-mapped data cache.
//   dcache_state_t : controller FSM states
//   OFFSET_W       : byte-offset bits within a 16-byte line
//   WORD_SEL_W     : 32-bit word select bits within a line
//   index_width()  : log2 of the number of sets (SETS must be a power of two)
package dcache_pkg;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } dcache_state_t;

  localparam int OFFSET_W   = 4;
  localparam int WORD_SEL_W = 2;

  function automatic int index_width(input int sets);
    int w;
    w = 0;
    while ((1 << w) < sets) w++;
    return w;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Bus interfaces of the data cache.
//   dcache_cpu_if : CPU load/store request and response
//     master = CPU side (drives req_*), slave = cache side (drives rdata, stall)
//   dcache_mem_if : 128-bit block port towards data memory
//     master = cache side (drives wr_en/addr/wdata), slave = memory (drives rdata)
interface dcache_cpu_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_we;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [3:0]               req_be;
  logic [31:0]              req_wdata;
  logic [31:0]              rdata;
  logic                     stall;

  modport master (output req_valid, req_we, req_addr, req_be, req_wdata,
                  input  rdata, stall);
  modport slave  (input  req_valid, req_we, req_addr, req_be, req_wdata,
                  output rdata, stall);
endinterface

interface dcache_mem_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 128
);
  logic                     mem_wr_en;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [BLOCK_WIDTH-1:0]   mem_wdata;
  logic [BLOCK_WIDTH-1:0]   mem_rdata;

  modport master (output mem_wr_en, mem_addr, mem_wdata, input  mem_rdata);
  modport slave  (input  mem_wr_en, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/dcache_array.sv
// dcache_array: line storage (valid, dirty, tag, 128-bit data) for the cache.
//   clk, rst_n   : clock; async active-low reset clears valid/dirty only
//   index        : line selected for both the combinational read and the write
//   rd_*         : current contents of the selected line
//   wr_en        : commit a write at the clock edge
//   wr_fill      : 1 = refill whole line (valid=1, dirty=0, new tag),
//                  0 = byte-merge a store word into the line (dirty=1)
//   wr_tag/wr_line            : refill tag and block
//   wr_word_sel/wr_be/wr_wdata: store word position, byte enables and data
module dcache_array
  import dcache_pkg::*;
#(
  parameter int SETS        = 256,
  parameter int INDEX_W     = 8,
  parameter int TAG_W       = 20,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_W-1:0]     index,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [BLOCK_WIDTH-1:0] rd_data,
  input  logic                   wr_en,
  input  logic                   wr_fill,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic [BLOCK_WIDTH-1:0] wr_line,
  input  logic [WORD_SEL_W-1:0]  wr_word_sel,
  input  logic [3:0]             wr_be,
  input  logic [31:0]            wr_wdata
);

  logic [SETS-1:0]        valid_reg;
  logic [SETS-1:0]        dirty_reg;
  logic [TAG_W-1:0]       tag_mem  [SETS];
  logic [BLOCK_WIDTH-1:0] data_mem [SETS];
  logic [BLOCK_WIDTH-1:0] merged_line;

  assign rd_valid = valid_reg[index];
  assign rd_dirty = dirty_reg[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[index];

  // Each byte lane takes the store byte only if it sits in the addressed word
  // and its enable is set; every other byte keeps the current line content.
  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_WIDTH / 8; gi++) begin : g_byte
      localparam int WORD = gi / 4;
      localparam int LANE = gi % 4;
      assign merged_line[gi*8 +: 8] =
        (wr_word_sel == WORD_SEL_W'(WORD) && wr_be[LANE]) ?
        wr_wdata[LANE*8 +: 8] : rd_data[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (wr_en) begin
      if (wr_fill) begin
        valid_reg[index] <= 1'b1;
        dirty_reg[index] <= 1'b0;
      end else begin
        dirty_reg[index] <= 1'b1;
      end
    end
  end

  // Tag and data are plain storage; only the valid/dirty bits need clearing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[index] <= wr_fill ? wr_line : merged_line;
      if (wr_fill) tag_mem[index] <= wr_tag;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
//   clk, rst_n : clock; async active-low reset
//   cpu        : CPU request/response (slave side): hits serve with no stall,
//                misses stall while dirty lines are evicted and blocks refilled
//   mem        : 128-bit block port (master side); mem_rdata is combinational
//                from mem_addr, writes take effect on the WRITEBACK edge
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int SETS          = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
);

  localparam int INDEX_W = index_width(SETS);
  localparam int TAG_W   = ADDRESS_WIDTH - INDEX_W - OFFSET_W;

  dcache_state_t state_reg, state_next;

  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_W-1:0]     req_index;
  logic [WORD_SEL_W-1:0]  word_sel;
  logic                   unused_addr_bits;

  logic                   line_valid, line_dirty, hit;
  logic [TAG_W-1:0]       line_tag;
  logic [BLOCK_WIDTH-1:0] line_data;
  logic                   arr_we, arr_fill;

  logic                   stall;
  logic [31:0]            rdata;
  logic                   mem_wr_en;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [BLOCK_WIDTH-1:0] mem_wdata;

  assign req_tag          = cpu.req_addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign req_index        = cpu.req_addr[OFFSET_W +: INDEX_W];
  assign word_sel         = cpu.req_addr[3:2];
  assign unused_addr_bits = ^cpu.req_addr[1:0];

  dcache_array #(
    .SETS        (SETS),
    .INDEX_W     (INDEX_W),
    .TAG_W       (TAG_W),
    .BLOCK_WIDTH (BLOCK_WIDTH)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .index       (req_index),
    .rd_valid    (line_valid),
    .rd_dirty    (line_dirty),
    .rd_tag      (line_tag),
    .rd_data     (line_data),
    .wr_en       (arr_we),
    .wr_fill     (arr_fill),
    .wr_tag      (req_tag),
    .wr_line     (mem.mem_rdata),
    .wr_word_sel (word_sel),
    .wr_be       (cpu.req_be),
    .wr_wdata    (cpu.req_wdata)
  );

  assign hit = line_valid && (line_tag == req_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= COMPARE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    rdata      = '0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    arr_we     = 1'b0;
    arr_fill   = 1'b0;
    case (state_reg)
      COMPARE: begin
        if (cpu.req_valid) begin
          if (hit) begin
            rdata  = line_data[{word_sel, 5'd0} +: 32];
            arr_we = cpu.req_we;
          end else begin
            stall      = 1'b1;
            state_next = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall      = 1'b1;
        mem_wr_en  = 1'b1;
        mem_addr   = {line_tag, req_index, {OFFSET_W{1'b0}}};
        mem_wdata  = line_data;
        state_next = ALLOCATE;
      end
      ALLOCATE: begin
        stall      = 1'b1;
        mem_addr   = {req_tag, req_index, {OFFSET_W{1'b0}}};
        arr_we     = 1'b1;
        arr_fill   = 1'b1;
        state_next = COMPARE;
      end
      default: state_next = COMPARE;
    endcase
    // While reset is held the lines read as invalid, so a pending request
    // would otherwise look like a miss; the CPU must see stall low instead.
    if (!rst_n) stall = 1'b0;
  end

  assign cpu.stall     = stall;
  assign cpu.rdata     = rdata;
  assign mem.mem_wr_en = mem_wr_en;
  assign mem.mem_addr  = mem_addr;
  assign mem.mem_wdata = mem_wdata;

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store stage and the 128-bit block data memory. It serves word and sub-word accesses from an internal line array. On a miss it drives the memory's block port (wr_en, addr, WriteBlockData, ReadBlockData) to evict dirty lines and refill 16-byte blocks. It is the initiator of that block protocol.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, byte address width on CPU and memory side
- BLOCK_WIDTH, 128, line size in bits; fixed at 16 bytes, so 4 offset bits
- SETS, 256, number of lines; power of two, so index = log2(SETS) bits

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU access request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDRESS_WIDTH  byte address; word-aligned, bits [1:0] ignored
- req_be  in  4  store byte enables within the addressed word
- req_wdata  in  32  store data
- rdata  out  32  load data, valid when req_valid and not stall
- stall  out  1  CPU must hold the request and freeze its pipeline
- mem_wr_en  out  1  block write strobe to memory
- mem_addr  out  ADDRESS_WIDTH  block address; low 4 bits always 0
- mem_wdata  out  BLOCK_WIDTH  eviction block, byte 0 in bits [7:0]
- mem_rdata  in  BLOCK_WIDTH  block read data; combinational from mem_addr

## Operation
- Address split:
  - offset = req_addr[3:0]
  - word select = req_addr[3:2]
  - index = req_addr[4 +: log2(SETS)]
  - tag = remaining upper bits
- Per-line state: valid, dirty, tag, 128-bit data.
- FSM states: COMPARE (reset state), WRITEBACK, ALLOCATE.
- COMPARE, hit (valid and tag match):
  - Load: rdata is the selected word, combinational.
  - Store: bytes with req_be set merge into the line at the clock edge, and dirty is set.
  - stall = 0.
- COMPARE, miss with req_valid:
  - stall = 1.
  - Next state is WRITEBACK if the line is valid and dirty, else ALLOCATE.
- WRITEBACK:
  - mem_wr_en = 1, mem_addr = {stored tag, index, 4'h0}, mem_wdata = line data.
  - Next state ALLOCATE. stall = 1.
- ALLOCATE:
  - mem_addr = {req tag, index, 4'h0}, mem_wr_en = 0.
  - At the edge, the line captures mem_rdata; valid = 1, dirty = 0, tag = req tag.
  - Next state COMPARE. stall = 1.
- After ALLOCATE, the held request hits in COMPARE. A store then merges and sets dirty.
- With req_valid = 0 in COMPARE: no state change, stall = 0, no memory traffic.
- The request must stay stable while stall = 1. Behaviour on a changed request is undefined; it is not checked.
- Outside WRITEBACK: mem_wr_en = 0 and mem_wdata = 0. mem_addr holds the last driven value only in ALLOCATE/WRITEBACK, otherwise 0.

## Timing
- Reset (async assert, sync release):
  - State = COMPARE.
  - All valid and dirty bits = 0; tag and data arrays are not reset.
  - mem_wr_en = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, stall = 0.
- Hit latency: 0 extra cycles. A load returns in the request cycle; a store commits at the end of it.
- Clean miss: stall for 2 cycles (COMPARE miss, ALLOCATE), served in the 3rd cycle.
- Dirty miss: stall for 3 cycles (COMPARE, WRITEBACK, ALLOCATE), served in the 4th cycle.
- Memory write takes effect on the WRITEBACK edge. The ALLOCATE read of a different block in the following cycle is unaffected.
- Reset during WRITEBACK or ALLOCATE:
  - Outputs drop to reset values immediately.
  - The partial refill is discarded and the line is invalid.
  - The eviction is lost only if reset arrives before the WRITEBACK edge.
- Store hit to a line at the same edge as no other event: only one line is ever updated per cycle, so no same-cycle conflicts exist.

## Structure
- Package dcache_pkg holds:
  - state enum dcache_state_t {COMPARE, WRITEBACK, ALLOCATE}
  - OFFSET_W = 4
  - WORD_SEL_W = 2
  - a function computing INDEX_W from SETS
- Sub-module dcache_array holds the valid/dirty/tag/data storage:
  - combinational read by index
  - one synchronous write port with line-fill and byte-merge modes
  - async clear of valid/dirty
- The FSM and address slicing live in dcache_ctrl.

## Test plan
- Reset, then load 0x0000_1000 with memory block 0x1000 = words {W3,W2,W1,W0}:
  - 2 stall cycles; mem_addr = 0x1000 in ALLOCATE; mem_wr_en never 1.
  - rdata = W0 in the 3rd cycle.
- Then load 0x1004: stall = 0 in the same cycle, rdata = W1, no memory activity.
- Store 0x1008, be = 4'b0011, wdata = 0xAABBCCDD: no stall. A following load of 0x1008 returns {W2[31:16], 16'hCCDD}.
- Load 0x2008 (same index 0, new tag):
  - WRITEBACK cycle: mem_wr_en = 1, mem_addr = 0x1000, mem_wdata word2 = {W2[31:16], 16'hCCDD}.
  - ALLOCATE cycle: mem_addr = 0x2000.
  - 3 stall cycles total.
- Load 0x1010 (index 1, clean invalid) directly after a hit on index 0: ALLOCATE only, 2 stall cycles, index 0 line unchanged.
- Assert rst_n = 0 mid-WRITEBACK:
  - mem_wr_en = 0 and stall = 0 immediately.
  - After release, load 0x1000 misses with no WRITEBACK (dirty cleared).
